// File: rtl/relu_grad_unit.sv
// relu_grad_unit: backward pass of the (leaky-)ReLU activation. FILL records pre-activation signs,
// BWD gates upstream gradients by them. Optional macro LEAKY_RELU_GRAD_EN scales negatives by LEAK.
module relu_grad_unit #(
  parameter int                 DEPTH  = 64,
  parameter int                 ADDR_W = $clog2(DEPTH),
  parameter logic signed [15:0] LEAK   = 16'sh001A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fwd_valid,
  input  logic [15:0] fwd_data,
  output logic        fwd_ready,
  input  logic        grad_in_valid,
  input  logic [15:0] grad_in_data,
  output logic        grad_in_ready,
  output logic        grad_out_valid,
  output logic [15:0] grad_out_data,
  input  logic        grad_out_ready,
  output logic        phase,
  output logic        bwd_done
);

  typedef enum logic {S_FILL = 1'b0, S_BWD = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] L_LAST_WR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   L_DEPTH    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   L_LAST_OUT = (ADDR_W + 1)'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_idx;
  logic [ADDR_W:0]     r_rd_idx;
  logic [ADDR_W:0]     r_out_cnt;
  logic                r_mask [DEPTH];
  logic                r_s1_valid;
  logic                r_s1_neg;
  logic signed [15:0]  r_s1_grad;
  logic                r_out_valid;
  logic [15:0]         r_out_data;
  logic                w_fwd_acc;
  logic                w_fill_last;
  logic                w_en;
  logic                w_in_rdy;
  logic                w_in_acc;
  logic                w_out_hs;
  logic                w_done;
  logic [15:0]         w_out_calc;

  assign w_fwd_acc   = (r_state == S_FILL) && fwd_valid;
  assign w_fill_last = w_fwd_acc && (r_wr_idx == L_LAST_WR);
  assign w_en        = !r_out_valid || grad_out_ready;
  assign w_in_rdy    = (r_state == S_BWD) && w_en && (r_rd_idx < L_DEPTH);
  assign w_in_acc    = w_in_rdy && grad_in_valid;
  assign w_out_hs    = r_out_valid && grad_out_ready;
  assign w_done      = w_out_hs && (r_out_cnt == L_LAST_OUT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_fill_last) w_state_nxt = S_BWD;  else w_state_nxt = S_FILL;
      S_BWD:   if (w_done)      w_state_nxt = S_FILL; else w_state_nxt = S_BWD;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Mask storage has no reset: every entry is rewritten before it is read in a pass.
  always_ff @(posedge clk) begin
    if (w_fwd_acc) r_mask[r_wr_idx] <= fwd_data[15];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_fwd_acc) r_wr_idx <= w_fill_last ? '0 : r_wr_idx + ADDR_W'(1);
      if (w_done) begin
        r_rd_idx  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in_acc) r_rd_idx  <= r_rd_idx + (ADDR_W + 1)'(1);
        if (w_out_hs) r_out_cnt <= r_out_cnt + (ADDR_W + 1)'(1);
      end
    end
  end

  // Two-stage pipeline; everything freezes while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_neg    <= 1'b0;
      r_s1_grad   <= 16'sh0000;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
    end else if (w_en) begin
      r_s1_valid <= w_in_acc;
      if (w_in_acc) begin
        r_s1_grad <= grad_in_data;
        r_s1_neg  <= r_mask[r_rd_idx[ADDR_W-1:0]];
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_out_data <= w_out_calc;
    end
  end

`ifdef LEAKY_RELU_GRAD_EN
  logic signed [31:0] w_prod;
  logic signed [31:0] w_shift;

  assign w_prod  = 32'(r_s1_grad) * 32'(LEAK);
  assign w_shift = w_prod >>> 8;

  always_comb begin
    w_out_calc = r_s1_grad;
    if (!r_s1_neg)                    w_out_calc = r_s1_grad;
    else if (w_shift > 32'sd32767)    w_out_calc = 16'h7FFF;
    else if (w_shift < -32'sd32768)   w_out_calc = 16'h8000;
    else                              w_out_calc = w_shift[15:0];
  end
`else
  always_comb begin
    w_out_calc = r_s1_grad;
    if (r_s1_neg) w_out_calc = 16'h0000;
    else          w_out_calc = r_s1_grad;
  end
`endif

  assign fwd_ready      = (r_state == S_FILL);
  assign grad_in_ready  = w_in_rdy;
  assign grad_out_valid = r_out_valid;
  assign grad_out_data  = r_out_data;
  assign phase          = (r_state == S_BWD);
  assign bwd_done       = w_done;

endmodule
